// File: rtl/add_pkg.sv
// add_pkg: shared state encoding and sizing helpers for the digit-serial adder.
package add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int num_digits(int width, int digit);
    return width / digit;
  endfunction
  function automatic int cnt_width(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit combinational full adder, a link of the digit ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: two's-complement add/subtract processed DIGIT bits per clock,
// least-significant digit first, with the carry registered between digits.
module serial_add_sub
  import add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(N);
  if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("serial_add_sub: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end
  state_e           state_q;
  logic [WIDTH-1:0] opa_q, opb_q, res_q, res_d, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, cout_q, ovf_q, last;
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] s;
  assign c[0] = carry_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    full_adder_cell u_fa (
      .a   (opa_q[i]),
      .b   (opb_q[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end
  // New digit enters at the top so the last digit leaves the result fully aligned
  assign res_d = (res_q >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));
  assign last = cnt_q == CW'(N - 1);
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          opa_q   <= opa_q >> DIGIT;
          opb_q   <= opb_q >> DIGIT;
          res_q   <= res_d;
          carry_q <= c[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= res_d;
            cout_q  <= c[DIGIT];
            ovf_q   <= c[DIGIT-1] ^ c[DIGIT];
          end
        end
        default: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            opa_q   <= a;
            opb_q   <= b ^ {WIDTH{sub}};
            carry_q <= cin;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum = sum_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: randomized scoreboard bench for the 8/1 adder plus directed
// latency/result checks on 8/4 and 16/16 instances.
module tb_serial_add_sub;
  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
    int         acc;
  } exp_t;
  logic clock = 1'b0, resetn = 1'b0;
  logic start0 = 0, sub0 = 0, cin0 = 0, busy0, done0, cout0, ovf0;
  logic [7:0] a0 = 0, b0 = 0, sum0;
  logic start1 = 0, sub1 = 0, cin1 = 0, busy1, done1, cout1, ovf1;
  logic [7:0] a1 = 0, b1 = 0, sum1;
  logic start2 = 0, sub2 = 0, cin2 = 0, busy2, done2, cout2, ovf2;
  logic [15:0] a2 = 0, b2 = 0, sum2;
  int cyc = 0, n_vec = 0, n_err = 0, model_done = 0;
  exp_t q[$];
  logic [7:0] last_s = 0;
  logic last_co = 0, last_ov = 0;
  serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut0 (
    .clock(clock), .resetn(resetn), .start(start0), .sub(sub0), .cin(cin0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0));
  serial_add_sub #(.WIDTH(8), .DIGIT(4)) dut1 (
    .clock(clock), .resetn(resetn), .start(start1), .sub(sub1), .cin(cin1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));
  serial_add_sub #(.WIDTH(16), .DIGIT(16)) dut2 (
    .clock(clock), .resetn(resetn), .start(start2), .sub(sub2), .cin(cin2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  // Reference: integer add of a and (sub ? ~b : b) plus cin; overflow from signed range
  function automatic logic [17:0] ref_add(int w, logic [15:0] a, logic [15:0] b, logic sub, logic cin);
    longint m = (64'sd1 <<< w) - 1;
    longint ua = longint'(a) & m;
    longint ub = (sub ? longint'(~b) : longint'(b)) & m;
    longint full = ua + ub + longint'(cin);
    longint half = 64'sd1 <<< (w - 1);
    longint sa = (ua >= half) ? ua - 2 * half : ua;
    longint sb = (ub >= half) ? ub - 2 * half : ub;
    longint ss = sa + sb + longint'(cin);
    logic ov = (ss >= half) || (ss < -half);
    logic co = ((full >>> w) & 1) != 0;
    logic [15:0] sm = 16'(full & m);
    return {ov, co, sm};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask
  task automatic drive0(logic [7:0] a, logic [7:0] b, logic sub, logic cin, logic st);
    logic [17:0] r;
    exp_t e;
    a0 = a; b0 = b; sub0 = sub; cin0 = cin; start0 = st;
    if (st && cyc + 1 > model_done) begin
      r = ref_add(8, {8'h0, a}, {8'h0, b}, sub, cin);
      e.s = r[7:0]; e.co = r[16]; e.ov = r[17]; e.acc = cyc + 1;
      q.push_back(e);
      model_done = cyc + 1 + 8;
    end
    @(posedge clock); #1;
  endtask
  task automatic drain0();
    int t = 0;
    while (q.size() > 0 && t < 40) begin
      @(posedge clock); #1;
      t++;
    end
    chk("drain0_timeout", q.size(), 0);
  endtask
  always @(negedge clock) begin
    if (resetn) begin
      if (q.size() > 0 && cyc == q[0].acc + 8) begin
        chk("done0", done0, 1); chk("busy0_at_done", busy0, 0);
        chk("sum0", sum0, q[0].s); chk("cout0", cout0, q[0].co); chk("ovf0", ovf0, q[0].ov);
        last_s = q[0].s; last_co = q[0].co; last_ov = q[0].ov;
        void'(q.pop_front());
      end else begin
        chk("busy0", busy0, (q.size() > 0 && cyc >= q[0].acc) ? 1 : 0);
        chk("done0_idle", done0, 0);
        chk("sum0_held", {cout0, ovf0, sum0}, {last_co, last_ov, last_s});
      end
    end
  end
  task automatic directed(int which, logic [15:0] a, logic [15:0] b, logic sub, logic cin, int n);
    logic [17:0] r;
    int acc, t;
    logic seen;
    r = ref_add(which == 1 ? 8 : 16, a, b, sub, cin);
    if (which == 1) begin a1 = a[7:0]; b1 = b[7:0]; sub1 = sub; cin1 = cin; start1 = 1; end
    else begin a2 = a; b2 = b; sub2 = sub; cin2 = cin; start2 = 1; end
    acc = cyc + 1;
    @(posedge clock); #1;
    start1 = 0; start2 = 0;
    seen = 0; t = 0;
    while (!seen && t < 20) begin
      @(negedge clock);
      seen = (which == 1) ? done1 : done2;
      t++;
    end
    chk($sformatf("dut%0d_seen_done", which), seen, 1);
    chk($sformatf("dut%0d_latency", which), cyc - acc, n);
    if (which == 1) chk("dut1_result", {ovf1, cout1, 8'h0, sum1}, {r[17:16], 8'h0, r[7:0]});
    else chk("dut2_result", {ovf2, cout2, sum2}, r);
    @(posedge clock); #1;
  endtask
  initial begin
    #2;
    chk("rst_outs0", {busy0, done0, cout0, ovf0, sum0}, 0);
    chk("rst_outs2", {busy2, done2, cout2, ovf2, sum2}, 0);
    @(posedge clock); #1;
    resetn = 1;
    @(posedge clock); #1;
    drive0(8'h5A, 8'h3C, 0, 0, 1);
    drive0(8'h00, 8'h00, 0, 0, 0);
    drain0();
    drive0(8'h10, 8'h20, 1, 1, 1);
    drive0(8'h00, 8'h00, 0, 0, 0);
    drain0();
    drive0(8'hFF, 8'h01, 0, 0, 1);
    drive0(8'h00, 8'h00, 0, 0, 0);
    drain0();
    for (int i = 0; i < 30; i++)
      drive0(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1);
    for (int i = 0; i < 200; i++)
      drive0(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    drive0(8'h00, 8'h00, 0, 0, 0);
    drain0();
    drive0(8'hC3, 8'h77, 1, 1, 1);
    drive0(8'h00, 8'h00, 0, 0, 0);
    drive0(8'h00, 8'h00, 0, 0, 0);
    #1;
    resetn = 0;
    #1;
    chk("async_rst_outs0", {busy0, done0, cout0, ovf0, sum0}, 0);
    q.delete();
    last_s = 0; last_co = 0; last_ov = 0; model_done = 0;
    #1;
    resetn = 1;
    @(posedge clock); #1;
    drive0(8'h01, 8'h01, 0, 0, 1);
    drive0(8'h00, 8'h00, 0, 0, 0);
    drain0();
    directed(1, 16'h007F, 16'h0001, 0, 0, 2);
    directed(1, 16'h0010, 16'h0020, 1, 1, 2);
    directed(2, 16'hFFFF, 16'h0000, 0, 1, 1);
    directed(2, 16'h7FFF, 16'h8000, 1, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
